// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one byte-wide UART transmitter among NREQ
// requesters, sending each granted word MSB byte first plus an optional terminator.
module uart_tx_scheduler #(
    parameter int         NREQ       = 4,
    parameter int         WORD_BYTES = 4,
    parameter bit         SEND_TERM  = 1'b1,
    parameter logic [7:0] TERM       = 8'h0A,
    localparam int        W          = 8 * WORD_BYTES,
    localparam int        GW         = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [GW-1:0]     grant_id
);

    localparam int                IDXW     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(WORD_BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_TERM} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    word_q, word_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [GW-1:0]   last_q, last_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            busy_q, busy_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic            found_s;
    logic [GW-1:0]   winner_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_s && req_valid[(int'(last_q) + k) % NREQ]) begin
                found_s  = 1'b1;
                winner_s = GW'((int'(last_q) + k) % NREQ);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state and output computation for the grant/serialize FSM.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;
        req_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    req_ready[winner_s] = 1'b1;
                    word_d     = req_data[int'(winner_s)*W +: W];
                    tx_data_d  = req_data[int'(winner_s)*W + W - 8 +: 8];
                    grant_id_d = winner_s;
                    last_d     = winner_s;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        if (SEND_TERM) begin
                            tx_data_d = TERM;
                            state_d   = ST_TERM;
                        end else begin
                            tx_valid_d = 1'b0;
                            busy_d     = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + IDXW'(1);
                        tx_data_d = word_q[(WORD_BYTES - 2 - int'(idx_q))*8 +: 8];
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_TERM: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops; pointer resets so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            last_q     <= GW'(NREQ - 1);
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule
